btn_csr_ctrl: RTL and testbench

- CSR-mapped controller for the Arty push-button bank at CSR address 0x001.
- Per channel: synchronises, debounces, detects configurable rising/falling edges, latches them into a pending register and raises one level interrupt to the core.
- Sits between the board pins and the CSR file; software reads stable button state, acknowledges events by CSR clear.

---
 rtl/btn_csr_ctrl_if.sv | 19 +
 rtl/btn_csr_ctrl.sv | 143 ++++++++++++++
 tb/tb_btn_csr_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/btn_csr_ctrl_if.sv
// CSR access bundle between the core's CSR file and btn_csr_ctrl.
// The master drives the access; the slave returns combinational read data.
interface btn_csr_ctrl_if;
    logic        csr_enable;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_data_in;
    logic [31:0] csr_data_out;

    modport master (
        output csr_enable, csr_addr, csr_op, csr_data_in,
        input  csr_data_out
    );

    modport slave (
        input  csr_enable, csr_addr, csr_op, csr_data_in,
        output csr_data_out
    );
endinterface

// File: rtl/btn_csr_ctrl.sv
// Push-button bank controller: synchronise, debounce, edge-latch into pending, level irq.
// Optional BTN_CSR_CTRL_TIMESTAMP_EN adds a cycle counter and first-event timestamp at CSR 'h005.
module btn_csr_ctrl #(
    parameter int               Width          = 4,
    parameter int               DebounceCycles = 16,
    parameter logic [11:0]      StateAddr      = 12'h001,
    parameter logic [11:0]      PendAddr       = 12'h003,
    parameter logic [11:0]      CfgAddr        = 12'h004,
    parameter logic [2*Width-1:0] CfgReset     = 'h0F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] btn_i,
    btn_csr_ctrl_if.slave    csr,
    output logic [Width-1:0] btn_state_o,
    output logic             irq_o
);

    localparam int CntW = $clog2(DebounceCycles);
    localparam int CfgW = 2 * Width;
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    localparam logic [1:0] OpRw = 2'b01;
    localparam logic [1:0] OpRs = 2'b10;
    localparam logic [1:0] OpRc = 2'b11;

    logic [Width-1:0] sync1_q, sync2_q;
    logic [Width-1:0] stable_q, stable_d;
    logic [Width-1:0] toggle;
    logic [Width-1:0] edge_set;
    logic [CntW-1:0]  cnt_q [Width];
    logic [CntW-1:0]  cnt_d [Width];
    logic [Width-1:0] pend_q, pend_d;
    logic [CfgW-1:0]  cfg_q, cfg_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            pend_q   <= '0;
            cfg_q    <= CfgReset;
            for (int i = 0; i < Width; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pend_q   <= pend_d;
            cfg_q    <= cfg_d;
            for (int i = 0; i < Width; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Counter is cleared on the terminal count, so it never wraps.
    always_comb begin
        stable_d = stable_q;
        toggle   = '0;
        edge_set = '0;
        for (int i = 0; i < Width; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    toggle[i]   = 1'b1;
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            edge_set[i] = toggle[i] & (stable_q[i] ? cfg_q[Width+i] : cfg_q[i]);
        end
    end

    logic             wr_en;
    logic [Width-1:0] pend_wdata;
    logic [CfgW-1:0]  cfg_wdata;
    logic             unused_data_hi;

    assign wr_en          = csr.csr_enable && (csr.csr_op != 2'b00);
    assign pend_wdata     = csr.csr_data_in[Width-1:0];
    assign cfg_wdata      = csr.csr_data_in[CfgW-1:0];
    assign unused_data_hi = ^csr.csr_data_in[31:CfgW];

    // Hardware edges are OR-ed in after the CSR update so a set beats a same-cycle clear.
    always_comb begin
        pend_d = pend_q;
        cfg_d  = cfg_q;
        if (wr_en && csr.csr_addr == PendAddr) begin
            case (csr.csr_op)
                OpRw:    pend_d = pend_wdata;
                OpRs:    pend_d = pend_q | pend_wdata;
                OpRc:    pend_d = pend_q & ~pend_wdata;
                default: pend_d = pend_q;
            endcase
        end
        if (wr_en && csr.csr_addr == CfgAddr) begin
            case (csr.csr_op)
                OpRw:    cfg_d = cfg_wdata;
                OpRs:    cfg_d = cfg_q | cfg_wdata;
                OpRc:    cfg_d = cfg_q & ~cfg_wdata;
                default: cfg_d = cfg_q;
            endcase
        end
        pend_d = pend_d | edge_set;
    end

`ifdef BTN_CSR_CTRL_TIMESTAMP_EN
    localparam logic [11:0] TsAddr = 12'h005;

    logic [31:0] ts_cnt_q;
    logic [31:0] ts_q;

    // Only the first event after pending drains captures a timestamp.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 32'd1;
            if ((|edge_set) && (pend_q == '0)) ts_q <= ts_cnt_q;
        end
    end
`endif

    always_comb begin
        csr.csr_data_out = '0;
        if (csr.csr_addr == StateAddr) begin
            csr.csr_data_out[Width-1:0] = stable_q;
        end else if (csr.csr_addr == PendAddr) begin
            csr.csr_data_out[Width-1:0] = pend_q;
        end else if (csr.csr_addr == CfgAddr) begin
            csr.csr_data_out[CfgW-1:0] = cfg_q;
        end
`ifdef BTN_CSR_CTRL_TIMESTAMP_EN
        else if (csr.csr_addr == TsAddr) begin
            csr.csr_data_out = ts_q;
        end
`endif
    end

    assign btn_state_o = stable_q;
    assign irq_o       = |pend_q;

endmodule

// File: tb/tb_btn_csr_ctrl.sv
// Directed bench for btn_csr_ctrl with Width=4, DebounceCycles=4.
module tb_btn_csr_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] btn_i;
    logic [3:0] btn_state_o;
    logic       irq_o;

    int vectors = 0;
    int errors  = 0;

    btn_csr_ctrl_if csr_if ();

    btn_csr_ctrl #(
        .Width          (4),
        .DebounceCycles (4),
        .StateAddr      (12'h001),
        .PendAddr       (12'h003),
        .CfgAddr        (12'h004),
        .CfgReset       (8'h0F)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_i       (btn_i),
        .csr         (csr_if.slave),
        .btn_state_o (btn_state_o),
        .irq_o       (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [11:0] addr, input string tag, input logic [31:0] exp);
        csr_if.csr_addr = addr;
        #1;
        chk(tag, csr_if.csr_data_out, exp);
    endtask

    task automatic csr_drive(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
        csr_if.csr_enable  = 1'b1;
        csr_if.csr_addr    = addr;
        csr_if.csr_op      = op;
        csr_if.csr_data_in = data;
    endtask

    task automatic csr_idle();
        csr_if.csr_enable  = 1'b0;
        csr_if.csr_op      = 2'b00;
        csr_if.csr_data_in = '0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
        csr_drive(addr, op, data);
        step(1);
        csr_idle();
    endtask

    initial begin
        reset = 1'b0;
        btn_i = 4'h0;
        csr_if.csr_addr = 12'h000;
        csr_idle();
        step(3);
        chk("irq_in_reset", {31'd0, irq_o}, 32'd0);
        reset = 1'b1;
        step(1);

        // reset state
        rd(12'h001, "rst_state", 32'h0);
        rd(12'h003, "rst_pend", 32'h0);
        rd(12'h004, "rst_cfg", 32'h0F);
        rd(12'h002, "unmapped", 32'h0);
`ifndef BTN_CSR_CTRL_TIMESTAMP_EN
        rd(12'h005, "ts_absent", 32'h0);
`endif
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        chk("rst_btn_state", {28'd0, btn_state_o}, 32'd0);

        // rise on ch0: accepted exactly 6 edges after the pin change
        btn_i = 4'b0001;
        step(5);
        chk("rise0_edge5", {28'd0, btn_state_o}, 32'h0);
        chk("rise0_irq5", {31'd0, irq_o}, 32'd0);
        step(1);
        chk("rise0_edge6", {28'd0, btn_state_o}, 32'h1);
        rd(12'h003, "rise0_pend", 32'h1);
        chk("rise0_irq", {31'd0, irq_o}, 32'd1);

        // 3-cycle glitch on ch1 is dropped
        btn_i = 4'b0011;
        step(3);
        btn_i = 4'b0001;
        step(8);
        chk("glitch_state", {28'd0, btn_state_o}, 32'h1);
        rd(12'h003, "glitch_pend", 32'h1);

        // writes to the state register are ignored
        wr(12'h001, 2'b01, 32'hF);
        rd(12'h001, "state_ro", 32'h1);

        // release ch0: fall disabled, pending unchanged
        btn_i = 4'b0000;
        step(6);
        chk("fall0_state", {28'd0, btn_state_o}, 32'h0);
        rd(12'h003, "fall0_pend", 32'h1);

        // RC on pending coinciding with a new rise on ch0: set wins
        btn_i = 4'b0001;
        step(5);
        csr_drive(12'h003, 2'b11, 32'h1);
        step(1);
        csr_idle();
        chk("race_state", {28'd0, btn_state_o}, 32'h1);
        rd(12'h003, "race_pend", 32'h1);
        wr(12'h003, 2'b11, 32'h1);
        rd(12'h003, "rc_pend", 32'h0);
        chk("rc_irq", {31'd0, irq_o}, 32'd0);

        // RS / RW on pending
        wr(12'h003, 2'b10, 32'h8);
        rd(12'h003, "rs_pend", 32'h8);
        chk("rs_irq", {31'd0, irq_o}, 32'd1);
        wr(12'h003, 2'b01, 32'h0);
        rd(12'h003, "rw_pend", 32'h0);
        chk("rw_irq", {31'd0, irq_o}, 32'd0);

        // fall-only config; upper write bits dropped
        wr(12'h004, 2'b01, 32'h0000_FFF0);
        rd(12'h004, "cfg_rw", 32'hF0);
        btn_i = 4'b0101;
        step(6);
        chk("press2_state", {28'd0, btn_state_o}, 32'h5);
        rd(12'h003, "press2_pend", 32'h0);
        btn_i = 4'b0001;
        step(5);
        chk("rel2_early_state", {28'd0, btn_state_o}, 32'h5);
        rd(12'h003, "rel2_early_pend", 32'h0);
        step(1);
        chk("rel2_state", {28'd0, btn_state_o}, 32'h1);
        rd(12'h003, "rel2_pend", 32'h4);
        chk("rel2_irq", {31'd0, irq_o}, 32'd1);

        // RC / RS on config
        wr(12'h004, 2'b11, 32'h10);
        rd(12'h004, "cfg_rc", 32'hE0);
        wr(12'h004, 2'b10, 32'h01);
        rd(12'h004, "cfg_rs", 32'hE1);
        wr(12'h004, 2'b00, 32'hFF);
        rd(12'h004, "cfg_op_none", 32'hE1);

        // reset mid-debounce: full latency restarts after release
        btn_i = 4'b0011;
        step(3);
        reset = 1'b0;
        step(1);
        rd(12'h004, "cfg_after_rst", 32'h0F);
        rd(12'h003, "pend_after_rst", 32'h0);
        reset = 1'b1;
        step(5);
        chk("rst_mid_edge5", {28'd0, btn_state_o}, 32'h0);
        step(1);
        chk("rst_mid_edge6", {28'd0, btn_state_o}, 32'h3);
        rd(12'h003, "rst_mid_pend", 32'h3);
        chk("rst_mid_irq", {31'd0, irq_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
